// File: rtl/if_fetch.sv
// Instruction fetch stage: program counter, imem request handshake, IF/ID register and pending-branch target.
// Optional IF_SKID_EN: buffer a word acknowledged during a stall (S_HOLD) instead of discarding and refetching it.
module if_fetch (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        branch_flag_i,
    input  logic [15:0] branch_addr_i,
    output logic        imem_req_o,
    output logic [15:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [15:0] imem_data_i,
    output logic [15:0] id_pc_o,
    output logic [15:0] id_inst_o,
    output logic        id_valid_o
);

    localparam logic [15:0] NOP_INST = 16'h0800;

    typedef enum logic [0:0] {
        S_REQ  = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [15:0] r_pc;
    logic [15:0] r_tgt;
    logic        r_tgt_valid;
    logic [15:0] r_id_pc;
    logic [15:0] r_id_inst;
    logic        r_id_valid;

    logic        w_accept;
    logic        w_bubble;
    logic        w_take_now;
    logic [15:0] w_pc_inc;
    logic [15:0] w_next_pc;
    logic [15:0] w_word;

`ifdef IF_SKID_EN
    logic [15:0] r_hold;
`endif

    // The request drops immediately while reset is held so nothing is issued from a stale pc.
    assign imem_req_o  = (r_state == S_REQ) & ~rst;
    assign imem_addr_o = r_pc;
    assign id_pc_o     = r_id_pc;
    assign id_inst_o   = r_id_inst;
    assign id_valid_o  = r_id_valid;

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_REQ;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode, accept/bubble qualification and source of the word entering IF/ID
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_bubble    = 1'b0;
        w_word      = imem_data_i;
        case (r_state)
            S_REQ: begin
                if (imem_ack_i && !stall_i) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_REQ;
                end else if (!imem_ack_i && !stall_i) begin
                    w_bubble    = 1'b1;
                    w_state_nxt = S_REQ;
                end else begin
`ifdef IF_SKID_EN
                    if (imem_ack_i) begin
                        w_state_nxt = S_HOLD;
                    end else begin
                        w_state_nxt = S_REQ;
                    end
`else
                    // Word acked under stall is dropped; the same address stays requested.
                    w_state_nxt = S_REQ;
`endif
                end
            end
            S_HOLD: begin
`ifdef IF_SKID_EN
                w_word = r_hold;
                if (!stall_i) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_REQ;
                end else begin
                    w_state_nxt = S_HOLD;
                end
`else
                w_state_nxt = S_REQ;
`endif
            end
            default: begin
                w_state_nxt = S_REQ;
            end
        endcase
    end

    // Branch redirect: a branch seen while no fetch completes is parked in the target register
    always_comb begin
        w_pc_inc   = r_pc + 16'd1;
        w_take_now = branch_flag_i & r_id_valid & ~stall_i;
        if (w_take_now) begin
            w_next_pc = branch_addr_i;
        end else if (r_tgt_valid) begin
            w_next_pc = r_tgt;
        end else begin
            w_next_pc = w_pc_inc;
        end
    end

    // Program counter, pending target and IF/ID pipeline register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc        <= 16'h0000;
            r_tgt       <= 16'h0000;
            r_tgt_valid <= 1'b0;
            r_id_pc     <= 16'h0000;
            r_id_inst   <= NOP_INST;
            r_id_valid  <= 1'b0;
        end else if (w_accept) begin
            r_pc        <= w_next_pc;
            r_tgt_valid <= 1'b0;
            r_id_pc     <= w_pc_inc;
            r_id_inst   <= w_word;
            r_id_valid  <= 1'b1;
        end else begin
            if (w_bubble) begin
                r_id_inst  <= NOP_INST;
                r_id_valid <= 1'b0;
            end
            if (w_take_now) begin
                r_tgt_valid <= 1'b1;
                r_tgt       <= branch_addr_i;
            end
        end
    end

`ifdef IF_SKID_EN
    // Skid buffer captures the word acknowledged while the pipeline is stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold <= 16'h0000;
        end else if ((r_state == S_REQ) && imem_ack_i && stall_i) begin
            r_hold <= imem_data_i;
        end else begin
            r_hold <= r_hold;
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch.sv
// Table-driven bench for if_fetch: each row drives one cycle of inputs, checks the request
// outputs before the clock edge and the IF/ID outputs after it.
module tb_if_fetch;

    localparam logic [15:0] NOP = 16'h0800;
`ifdef IF_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        stall_i;
    logic        branch_flag_i;
    logic [15:0] branch_addr_i;
    logic        imem_req_o;
    logic [15:0] imem_addr_o;
    logic        imem_ack_i;
    logic [15:0] imem_data_i;
    logic [15:0] id_pc_o;
    logic [15:0] id_inst_o;
    logic        id_valid_o;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic        rst;
        logic        stall;
        logic        bf;
        logic [15:0] ba;
        logic        ack;
        logic [15:0] data;
        logic        e_req;
        logic [15:0] e_addr;
        logic [15:0] e_pc;
        logic [15:0] e_inst;
        logic        e_valid;
    } vec_t;

    vec_t vq[$];

    if_fetch dut (
        .clk           (clk),
        .rst           (rst),
        .stall_i       (stall_i),
        .branch_flag_i (branch_flag_i),
        .branch_addr_i (branch_addr_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_ack_i    (imem_ack_i),
        .imem_data_i   (imem_data_i),
        .id_pc_o       (id_pc_o),
        .id_inst_o     (id_inst_o),
        .id_valid_o    (id_valid_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic s, input logic bf, input logic [15:0] ba,
                                input logic ack, input logic [15:0] d, input logic e_req,
                                input logic [15:0] e_addr, input logic [15:0] e_pc,
                                input logic [15:0] e_inst, input logic e_valid);
        vec_t v;
        v.rst = r; v.stall = s; v.bf = bf; v.ba = ba; v.ack = ack; v.data = d;
        v.e_req = e_req; v.e_addr = e_addr; v.e_pc = e_pc; v.e_inst = e_inst; v.e_valid = e_valid;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step(input vec_t v, input string tag);
        @(negedge clk);
        rst           = v.rst;
        stall_i       = v.stall;
        branch_flag_i = v.bf;
        branch_addr_i = v.ba;
        imem_ack_i    = v.ack;
        imem_data_i   = v.data;
        #1;
        chk({tag, ".req"},  {15'd0, imem_req_o}, {15'd0, v.e_req});
        chk({tag, ".addr"}, imem_addr_o, v.e_addr);
        @(posedge clk);
        #1;
        chk({tag, ".id_pc"},    id_pc_o, v.e_pc);
        chk({tag, ".id_inst"},  id_inst_o, v.e_inst);
        chk({tag, ".id_valid"}, {15'd0, id_valid_o}, {15'd0, v.e_valid});
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; stall_i = 1'b0; branch_flag_i = 1'b0; branch_addr_i = 16'h0000;
        imem_ack_i = 1'b0; imem_data_i = 16'h0000;
        @(posedge clk);
        #1;

        //               rst   stall bf    ba        ack   data      req   addr      id_pc     id_inst   valid
        // reset with a coincident ack, then zero-wait streaming
        vq.push_back(mk(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h1234, 1'b0, 16'h0000, 16'h0000, NOP,      1'b0));
        vq.push_back(mk(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'hA000, 1'b1, 16'h0000, 16'h0001, 16'hA000, 1'b1));
        vq.push_back(mk(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'hA001, 1'b1, 16'h0001, 16'h0002, 16'hA001, 1'b1));
        vq.push_back(mk(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'hA002, 1'b1, 16'h0002, 16'h0003, 16'hA002, 1'b1));
        vq.push_back(mk(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'hA003, 1'b1, 16'h0003, 16'h0004, 16'hA003, 1'b1));
        // two wait states per fetch
        vq.push_back(mk(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'hFFFF, 1'b1, 16'h0004, 16'h0004, NOP,      1'b0));
        vq.push_back(mk(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'hFFFF, 1'b1, 16'h0004, 16'h0004, NOP,      1'b0));
        vq.push_back(mk(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'hB004, 1'b1, 16'h0004, 16'h0005, 16'hB004, 1'b1));
        vq.push_back(mk(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'hFFFF, 1'b1, 16'h0005, 16'h0005, NOP,      1'b0));
        vq.push_back(mk(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'hFFFF, 1'b1, 16'h0005, 16'h0005, NOP,      1'b0));
        vq.push_back(mk(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'hB005, 1'b1, 16'h0005, 16'h0006, 16'hB005, 1'b1));
        // branch to 0x000F with same-cycle delay slot, then branch at 0x0010 to 0x0040
        vq.push_back(mk(1'b0, 1'b0, 1'b1, 16'h000F, 1'b1, 16'hC006, 1'b1, 16'h0006, 16'h0007, 16'hC006, 1'b1));
        vq.push_back(mk(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h1234, 1'b1, 16'h000F, 16'h0010, 16'h1234, 1'b1));
        vq.push_back(mk(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'hB010, 1'b1, 16'h0010, 16'h0011, 16'hB010, 1'b1));
        vq.push_back(mk(1'b0, 1'b0, 1'b1, 16'h0040, 1'b1, 16'hD011, 1'b1, 16'h0011, 16'h0012, 16'hD011, 1'b1));
        vq.push_back(mk(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'hE040, 1'b1, 16'h0040, 16'h0041, 16'hE040, 1'b1));
        // branch to 0x0080 whose delay slot is acked three cycles later; flag during bubbles ignored
        vq.push_back(mk(1'b0, 1'b0, 1'b1, 16'h0080, 1'b0, 16'hFFFF, 1'b1, 16'h0041, 16'h0041, NOP,      1'b0));
        vq.push_back(mk(1'b0, 1'b0, 1'b1, 16'h0999, 1'b0, 16'hFFFF, 1'b1, 16'h0041, 16'h0041, NOP,      1'b0));
        vq.push_back(mk(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'hFFFF, 1'b1, 16'h0041, 16'h0041, NOP,      1'b0));
        vq.push_back(mk(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'hF041, 1'b1, 16'h0041, 16'h0042, 16'hF041, 1'b1));
        vq.push_back(mk(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h7080, 1'b1, 16'h0080, 16'h0081, 16'h7080, 1'b1));
        // three-cycle stall with ack in the first stall cycle (branch flag ignored under stall)
        vq.push_back(mk(1'b0, 1'b1, 1'b1, 16'h0300, 1'b1, 16'h5081, 1'b1, 16'h0081, 16'h0081, 16'h7080, 1'b1));
        vq.push_back(mk(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'hFFFF, !SKID, 16'h0081, 16'h0081, 16'h7080, 1'b1));
        vq.push_back(mk(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'hFFFF, !SKID, 16'h0081, 16'h0081, 16'h7080, 1'b1));
        vq.push_back(mk(1'b0, 1'b0, 1'b0, 16'h0000, !SKID, SKID ? 16'hDEAD : 16'h5081, !SKID,
                        16'h0081, 16'h0082, 16'h5081, 1'b1));
        vq.push_back(mk(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h6082, 1'b1, 16'h0082, 16'h0083, 16'h6082, 1'b1));
        // pc wrap at 0xFFFF
        vq.push_back(mk(1'b0, 1'b0, 1'b1, 16'hFFFF, 1'b1, 16'h1111, 1'b1, 16'h0083, 16'h0084, 16'h1111, 1'b1));
        vq.push_back(mk(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h2222, 1'b1, 16'hFFFF, 16'h0000, 16'h2222, 1'b1));
        vq.push_back(mk(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h3333, 1'b1, 16'h0000, 16'h0001, 16'h3333, 1'b1));
        // reset while a request to 0x0123 is outstanding
        vq.push_back(mk(1'b0, 1'b0, 1'b1, 16'h0123, 1'b1, 16'h4444, 1'b1, 16'h0001, 16'h0002, 16'h4444, 1'b1));
        vq.push_back(mk(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'hFFFF, 1'b1, 16'h0123, 16'h0002, NOP,      1'b0));
        vq.push_back(mk(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h9999, 1'b0, 16'h0123, 16'h0000, NOP,      1'b0));
        vq.push_back(mk(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'hFFFF, 1'b1, 16'h0000, 16'h0000, NOP,      1'b0));
        vq.push_back(mk(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'hAAAA, 1'b1, 16'h0000, 16'h0001, 16'hAAAA, 1'b1));

        foreach (vq[i]) step(vq[i], $sformatf("v%0d", i));

        // Hand sequence: reset must discard a parked branch target
        step(mk(1'b0, 1'b0, 1'b1, 16'h0500, 1'b0, 16'hFFFF, 1'b1, 16'h0001, 16'h0001, NOP,      1'b0), "h0");
        step(mk(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'hFFFF, 1'b0, 16'h0001, 16'h0000, NOP,      1'b0), "h1");
        step(mk(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0B0B, 1'b1, 16'h0000, 16'h0001, 16'h0B0B, 1'b1), "h2");
        step(mk(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0C0C, 1'b1, 16'h0001, 16'h0002, 16'h0C0C, 1'b1), "h3");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
